// File: rtl/commonread_buffer.sv
// -----------------------------------------------------------------------------
// commonread_buffer
//
// Decouples an upstream BRAM line reader from a downstream consumer. Lines
// enter through in_valid/in_data and are held in a DEPTH-entry circular FIFO.
// The FIFO is first-word fall-through: the head line is always visible on
// out_data while out_valid is high. A registered almost-full signal throttles
// the upstream reader early enough to cover its pipeline latency. A small
// IDLE/RUN controller counts delivered lines for a transfer started by
// op_start, and pulses op_done once the configured line count has been popped.
//
// Ports
//   clk            single clock for all logic
//   reset          asynchronous active-low reset
//   op_start       1-cycle pulse, starts a transfer (ignored while running)
//   configreg      [31:16] line count of the transfer, [15:0] unused
//   in_valid       upstream line present this cycle
//   in_data        upstream line
//   in_almostfull  registered backpressure to the upstream reader
//   out_valid      head line available (FIFO not empty)
//   out_data       head line
//   out_ready      downstream accepts the head line this cycle
//   op_done        1-cycle pulse after the last line of a transfer is popped
//   overflow       sticky: a line arrived while full and was dropped
// -----------------------------------------------------------------------------
module commonread_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_almostfull,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  op_done,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic push;
  logic pop;
  logic drop;

  // The low half of configreg carries no meaning for this block.
  logic unused_cfg;
  assign unused_cfg = ^configreg[15:0];

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign pop  = out_valid & out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a new line when the consumer is draining it.
  assign push = in_valid & ((count != FULL_LEVEL) | pop);
  assign drop = in_valid & ~push;

  // NOTE: the line storage has no reset; stale contents are never visible
  // because out_valid is derived from count, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      in_almostfull <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Asserted from the current occupancy, so it reaches the upstream
      // reader one cycle later; AF_MARGIN covers that and the read pipeline.
      in_almostfull <= (count >= AF_LEVEL);
      overflow      <= overflow | drop;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer controller
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [15:0] length;
  logic [15:0] delivered;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      length    <= '0;
      delivered <= '0;
      op_done   <= 1'b0;
    end else begin
      op_done <= 1'b0;
      case (state)
        IDLE: begin
          // Pops seen here belong to no transfer and are not counted.
          if (op_start) begin
            length    <= configreg[31:16];
            delivered <= '0;
            if (configreg[31:16] == 16'd0) begin
              op_done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // A second op_start while a transfer is running has no effect.
          if (pop) begin
            delivered <= delivered + 16'd1;
            if (delivered + 16'd1 == length) begin
              op_done <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commonread_buffer.sv
// -----------------------------------------------------------------------------
// tb_commonread_buffer
//
// Drives commonread_buffer through directed scenarios followed by a random
// phase. A reference model (a queue of lines plus a transfer counter) predicts
// every output each cycle; outputs are sampled just after the falling edge.
// -----------------------------------------------------------------------------
module tb_commonread_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_start;
  logic [31:0]   configreg;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_almostfull;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          op_done;
  logic          overflow;

  commonread_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AFM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op_start      (op_start),
    .configreg     (configreg),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_almostfull (in_almostfull),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .op_done       (op_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: current visible outputs are m_af, m_done, m_ovf
  // and the queue head; the queue holds lines in arrival order.
  logic [DW-1:0] q[$];
  bit            m_af;
  bit            m_done;
  bit            m_ovf;
  bit            m_run;
  int            m_len;
  int            m_del;

  // Observed event counters used by scenario-level checks.
  int done_seen = 0;
  int pops_seen = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_af   = 1'b0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_run  = 1'b0;
    m_len  = 0;
    m_del  = 0;
  endtask

  task automatic idle_inputs();
    op_start  = 1'b0;
    configreg = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) check("out_data", out_data, q[0]);
    check("in_almostfull", in_almostfull, m_af);
    check("op_done", op_done, m_done);
    check("overflow", overflow, m_ovf);
  endtask

  // One clock cycle: apply inputs, compare the outputs of this cycle with the
  // model, then advance the model to what the next cycle should show.
  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       input logic start, input logic [15:0] len);
    bit do_pop;
    bit do_push;
    bit n_done;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    op_start  = start;
    configreg = {len, 16'($urandom)};
    #1;
    check_outputs();
    if (op_done) done_seen++;
    if (out_valid && ordy) pops_seen++;

    do_pop  = (q.size() != 0) && ordy;
    do_push = iv && ((q.size() < DEPTH) || do_pop);
    n_done  = 1'b0;
    if (!m_run) begin
      if (start) begin
        m_len = int'(len);
        m_del = 0;
        if (len == 16'd0) n_done = 1'b1;
        else              m_run  = 1'b1;
      end
    end else if (do_pop) begin
      m_del++;
      if (m_del == m_len) begin
        n_done = 1'b1;
        m_run  = 1'b0;
      end
    end
    if (iv && !do_push) m_ovf = 1'b1;
    m_af   = (q.size() >= DEPTH - AFM);
    m_done = n_done;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(id);
  endtask

  // Asynchronous reset in the middle of a clock phase.
  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_almostfull", in_almostfull, 1'b0);
    check("rst op_done", op_done, 1'b0);
    check("rst overflow", overflow, 1'b0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int d0;
    int p0;
    reset = 1'b0;
    idle_inputs();
    model_clear();
    repeat (3) @(negedge clk);
    check("init out_valid", out_valid, 1'b0);
    check("init in_almostfull", in_almostfull, 1'b0);
    check("init op_done", op_done, 1'b0);
    check("init overflow", overflow, 1'b0);
    reset = 1'b1;

    // Streaming: length 8, data 0..7, consumer always ready.
    d0 = done_seen;
    cycle(1'b0, '0, 1'b1, 1'b1, 16'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0, 16'd0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 16'd0);
    check("stream done count", DW'(done_seen - d0), DW'(1));

    // Zero length: done one cycle later, controller stays idle.
    d0 = done_seen;
    cycle(1'b0, '0, 1'b0, 1'b1, 16'd0);
    repeat (3) cycle(1'b1, rnd_line(), 1'b1, 1'b0, 16'd0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 16'd0);
    check("zero-len done count", DW'(done_seen - d0), DW'(1));

    // Backpressure: fill to 16 with no pops; almost-full tracked by model.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd_line(), 1'b0, 1'b0, 16'd0);
    // Full push/pop: occupancy stays 16, order preserved across wrap.
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_line(), 1'b1, 1'b0, 16'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, 16'd0);
    check("full push/pop no overflow", overflow, 1'b0);
    // 17th line with no pop is dropped.
    cycle(1'b1, rnd_line(), 1'b0, 1'b0, 16'd0);
    cycle(1'b0, '0, 1'b0, 1'b0, 16'd0);
    check("overflow set", overflow, 1'b1);
    p0 = pops_seen;
    repeat (DEPTH + 4) cycle(1'b0, '0, 1'b1, 1'b0, 16'd0);
    check("drain after overflow", DW'(pops_seen - p0), DW'(DEPTH));
    apply_reset();

    // Ignored start: length 3 running, second start with length 5 ignored.
    d0 = done_seen;
    cycle(1'b0, '0, 1'b1, 1'b1, 16'd3);
    cycle(1'b1, rnd_line(), 1'b1, 1'b1, 16'd5);
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_line(), 1'b1, 1'b0, 16'd0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 16'd0);
    check("ignored start done count", DW'(done_seen - d0), DW'(1));

    // Mid-transfer reset after 3 of 8 pops, then a fresh length-2 transfer.
    cycle(1'b0, '0, 1'b0, 1'b1, 16'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, rnd_line(), 1'b0, 1'b0, 16'd0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 16'd0);
    d0 = done_seen;
    apply_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 16'd0);
    check("post-reset empty", out_valid, 1'b0);
    check("no done on abort", DW'(done_seen - d0), DW'(0));
    cycle(1'b0, '0, 1'b1, 1'b1, 16'd2);
    cycle(1'b1, rnd_line(), 1'b1, 1'b0, 16'd0);
    cycle(1'b1, rnd_line(), 1'b1, 1'b0, 16'd0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 16'd0);
    check("restart done count", DW'(done_seen - d0), DW'(1));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), rnd_line(), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 16'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
